// File: rtl/mem_responder.sv
// Single-port byte-addressed memory responder with a fixed, programmable
// request-to-response latency and big-endian byte lanes.
`timescale 1ns/1ps
module mem_responder #(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic        mem_write_en,
  input  logic [7:0]  mem_data_in  [0:3],
  output logic [7:0]  mem_data_out [0:3],
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned CW = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [CW-1:0] cnt;
  logic [31:0]   lat_addr;
  logic          lat_we;
  logic [7:0]    lat_data [0:3];
  logic [7:0]    storage [DEPTH_BYTES];

  logic          accept_c;
  logic          done_c;
  logic          err_c;
  logic [AW-1:0] base_c;

  assign err_c  = (lat_addr[1:0] != 2'b00) || (lat_addr > 32'(DEPTH_BYTES - 4));
  assign base_c = lat_addr[AW-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode; requests outside IDLE are simply not seen
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: if (mem_req) begin
        accept_c   = 1'b1;
        next_state = WAIT;
      end
      WAIT: if (cnt == '0) begin
        done_c     = 1'b1;
        next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture, latency counter and registered response
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt       <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        lat_data[k]     <= 8'h00;
        mem_data_out[k] <= 8'h00;
      end
    end else begin
      mem_ready <= done_c;
      mem_err   <= done_c && err_c;
      if (accept_c) begin
        cnt      <= CW'(LATENCY - 1);
        lat_addr <= mem_addr;
        lat_we   <= mem_write_en;
        for (int k = 0; k < 4; k++) lat_data[k] <= mem_data_in[k];
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (done_c) begin
        if (err_c) begin
          for (int k = 0; k < 4; k++) mem_data_out[k] <= 8'h00;
        end else if (!lat_we) begin
          for (int k = 0; k < 4; k++) mem_data_out[k] <= storage[base_c + AW'(k)];
        end
      end
    end
  end

  // Storage has no reset; a write lands only on a clean completion
  always_ff @(posedge clk) begin
    if (done_c && lat_we && !err_c) begin
      for (int k = 0; k < 4; k++) storage[base_c + AW'(k)] <= lat_data[k];
    end
  end

endmodule
